// File: rtl/param_shift_reg.sv
// param_shift_reg -- parametrised universal shift register.
// DEPTH stages of DATA_W bits, each with its own valid bit. Supports hold,
// shift right (toward stage DEPTH-1), shift left (toward stage 0) and
// parallel load, with an occupancy count derived from the valid bits.
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, rot=1 during
// a shift feeds the ejected stage back into the vacated end. When it is not
// defined, rot is accepted but ignored.
module param_shift_reg #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       sin_r,
  input  logic                    sin_r_valid,
  input  logic [DATA_W-1:0]       sin_l,
  input  logic                    sin_l_valid,
  input  logic [DEPTH*DATA_W-1:0] pin,
  input  logic [DEPTH-1:0]        pin_valid,
  input  logic                    rot,
  output logic [DATA_W-1:0]       sout_r,
  output logic                    sout_r_valid,
  output logic [DATA_W-1:0]       sout_l,
  output logic                    sout_l_valid,
  output logic [DEPTH*DATA_W-1:0] pout,
  output logic [DEPTH-1:0]        pvalid,
  output logic [CNT_W-1:0]        count,
  output logic                    full,
  output logic                    empty
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;

  // Word and valid that enter the vacated end of the register on a shift.
  logic [DATA_W-1:0] fill_r_data;
  logic              fill_r_valid;
  logic [DATA_W-1:0] fill_l_data;
  logic              fill_l_valid;

`ifdef SHIFT_ROTATE_EN
  // Choose between the serial inputs and the ejected stage (rotate).
  always_comb begin
    if (rot) begin
      fill_r_data  = stage_q[DEPTH-1];
      fill_r_valid = valid_q[DEPTH-1];
      fill_l_data  = stage_q[0];
      fill_l_valid = valid_q[0];
    end else begin
      fill_r_data  = sin_r;
      fill_r_valid = sin_r_valid;
      fill_l_data  = sin_l;
      fill_l_valid = sin_l_valid;
    end
  end
`else
  // Without rotate support the serial inputs always fill the vacated end.
  always_comb begin
    fill_r_data  = sin_r;
    fill_r_valid = sin_r_valid;
    fill_l_data  = sin_l;
    fill_l_valid = sin_l_valid;
  end

  // The rot port is kept for interface compatibility but has no function here.
  logic unused_rot;
  assign unused_rot = rot;
`endif

  // Next-state selection for every stage and valid bit.
  always_comb begin
    // NOTE: defaults come first so every path assigns every bit; otherwise a
    // latch would be inferred to hold the value.
    stage_d = stage_q;
    valid_d = valid_q;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHR: begin
          stage_d[0] = fill_r_data;
          valid_d[0] = fill_r_valid;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
            valid_d[i] = valid_q[i-1];
          end
        end
        MODE_SHL: begin
          stage_d[DEPTH-1] = fill_l_data;
          valid_d[DEPTH-1] = fill_l_valid;
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
            valid_d[i] = valid_q[i+1];
          end
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = pin[i*DATA_W +: DATA_W];
          end
          valid_d = pin_valid;
        end
        default: ; // MODE_HOLD keeps the defaults
      endcase
    end
  end

  // State registers with synchronous reset; reset wins over en and mode.
  always_ff @(posedge clk) begin
    // NOTE: stages are discrete flops rather than a RAM, so they can and do
    // get cleared in reset; non-blocking assignments keep all stages
    // sampling the pre-edge values.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  end

  // Occupancy is a popcount of the valid bits, so it tracks pvalid exactly.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(valid_q[i]);
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Outputs are straight wiring from the state registers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_pout
    assign pout[g*DATA_W +: DATA_W] = stage_q[g];
  end

  assign pvalid       = valid_q;
  assign sout_r       = stage_q[DEPTH-1];
  assign sout_r_valid = valid_q[DEPTH-1];
  assign sout_l       = stage_q[0];
  assign sout_l_valid = valid_q[0];

endmodule
